// File: rtl/nested_if_seq_ctrl.sv
// Sequential nested-if select/add controller: one shared W+1-bit adder, valid/ready on both sides.
// Optional OUT->EVAL bypass enabled by defining NESTED_IF_SEQ_CTRL_BYPASS_EN.
module nested_if_seq_ctrl #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic [W-1:0] e,
    input  logic [W-1:0] f,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   o1,
    output logic [W:0]   o2,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_ADD_O1,
        S_ADD_O2,
        S_OUT
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_a, r_b, r_c, r_d, r_e, r_f;
    logic [W-1:0] r_x, r_y;
    logic [W:0]   r_o1, r_o2;
    logic [W-1:0] w_add_op;
    logic [W:0]   w_sum;
    logic [W-1:0] w_x, w_y;
    logic         w_load;

    // Shared adder: r_a is always one operand, the other is chosen by state.
    always_comb begin
        w_add_op = '0;
        case (r_state)
            S_EVAL:   w_add_op = W'(1);
            S_ADD_O1: w_add_op = r_x;
            S_ADD_O2: w_add_op = r_y;
            default:  w_add_op = '0;
        endcase
    end

    assign w_sum = {1'b0, r_a} + {1'b0, w_add_op};

    // The (a+1)>3 arm can never win after a>2 fails, but is kept in the mux.
    always_comb begin
        w_x = r_f;
        w_y = W'(5);
        if (r_a > W'(1)) begin
            w_y = r_e;
            if (r_a > W'(2)) begin
                w_x = r_b;
            end else if (w_sum > (W+1)'(3)) begin
                w_x = r_c;
            end else begin
                w_x = r_d;
            end
        end
    end

    assign w_load = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_next = S_EVAL;
            S_EVAL:   w_next = S_ADD_O1;
            S_ADD_O1: w_next = S_ADD_O2;
            S_ADD_O2: w_next = S_OUT;
            S_OUT: begin
                if (out_ready) begin
`ifdef NESTED_IF_SEQ_CTRL_BYPASS_EN
                    w_next = in_valid ? S_EVAL : S_IDLE;
`else
                    w_next = S_IDLE;
`endif
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == S_OUT);
        busy      = (r_state != S_IDLE);
`ifdef NESTED_IF_SEQ_CTRL_BYPASS_EN
        in_ready  = (r_state == S_IDLE) | ((r_state == S_OUT) & out_ready);
`else
        in_ready  = (r_state == S_IDLE);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_c  <= '0;
            r_d  <= '0;
            r_e  <= '0;
            r_f  <= '0;
            r_x  <= '0;
            r_y  <= '0;
            r_o1 <= '0;
            r_o2 <= '0;
        end else begin
            if (w_load) begin
                r_a <= a;
                r_b <= b;
                r_c <= c;
                r_d <= d;
                r_e <= e;
                r_f <= f;
            end
            if (r_state == S_EVAL) begin
                r_x <= w_x;
                r_y <= w_y;
            end
            if (r_state == S_ADD_O1) r_o1 <= w_sum;
            if (r_state == S_ADD_O2) r_o2 <= w_sum;
        end
    end

    assign o1 = r_o1;
    assign o2 = r_o2;

endmodule

// File: doc/nested_if_seq_ctrl.md
# nested_if_seq_ctrl

Sequential controller that wraps the nested-if select/add datapath behind valid/ready handshakes. It time-multiplexes a single 5-bit adder across three uses: the `(a + 1) > 3` compare, `o1 = x + a` and `o2 = y + a`. It sits between an operand producer and a result consumer in the cfg test suite. It exercises FSM sequencing of a shared arithmetic resource.

## Interface
- `W`, default 4: operand width; results are `W+1` bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: operand set `a..f` is valid.
- `in_ready` out 1: controller accepts an operand set.
- `a`, `b`, `c`, `d`, `e`, `f` in W each: operands; captured on input handshake.
- `out_valid` out 1: `o1`/`o2` hold a completed result.
- `out_ready` in 1: consumer accepts the result.
- `o1` out W+1: `x + a`.
- `o2` out W+1: `y + a`.
- `busy` out 1: FSM not in IDLE.

## Operation
- There is one adder instance, zero-extended W+1 bits. Its operand mux is selected by state. No other `+` is allowed in the block.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid`, latch `a..f` into operand regs and go to EVAL.
- **EVAL**
  - Adder computes `a+1`.
  - If `a>1`: `y=e`, and `x` is selected as:
    - `b` if `a>2`;
    - else `c` if `(a+1)>3`, using the full W+1-bit sum with no wrap;
    - else `d`.
  - Else `x=f`, `y=5` (truncated to W).
  - Latch `x` and `y`, then go to ADD_O1.
- **ADD_O1:** adder computes `x+a`, latched into the `o1` reg. Go to ADD_O2.
- **ADD_O2:** adder computes `y+a`, latched into the `o2` reg. Go to OUT.
- **OUT**
  - `out_valid=1`; `o1`/`o2` are stable.
  - On `out_ready`, go to IDLE.
  - `in_ready=0`, except as described under Configuration.
- All comparisons are unsigned.
- Sums are W+1 bits and never overflow.
- The `c` branch is unreachable for unsigned `a` and must still be present structurally.
- Reset (any state, any time):
  - state goes to IDLE;
  - `o1`, `o2`, `x`, `y` and operand regs go to 0;
  - `out_valid=0`, `busy=0`, `in_ready=1` (once `rst_n` is high).
  - An in-flight transaction is discarded, with no partial output.
- `in_valid` in states other than IDLE is ignored; the producer holds its data.
- `out_ready` outside OUT is ignored.

## Timing
- **Input handshake:** `in_valid & in_ready` sampled at edge E0.
- **Result timing:**
  - EVAL during E0→E1.
  - `o1` latched at E2.
  - `o2` latched at E3.
  - `out_valid` rises after E3.
  - Latency from acceptance to `out_valid` is 3 cycles.
- **Output handshake:** `out_valid & out_ready` sampled at edge Ek. `out_valid` drops after Ek.
- **Outputs:**
  - `o1`/`o2` are registered.
  - They keep their last value after handshake, until overwritten in the next ADD states.
- **Throughput:** with no backpressure, 1 result per 5 cycles (EVAL, ADD_O1, ADD_O2, OUT, IDLE).
- **Combinational paths:**
  - `in_ready` and `out_valid` are decoded from state only.
  - No combinational in→out path exists, except the bypass path under Configuration.

## Configuration
- Macro: `NESTED_IF_SEQ_CTRL_BYPASS_EN`.
- **Defined:**
  - In OUT, `in_ready = out_ready`.
  - A simultaneous output handshake and input handshake at the same edge latches the new operands and goes directly to EVAL, skipping IDLE.
  - Throughput is 1 per 4 cycles.
  - Adds a combinational `out_ready`→`in_ready` path.
- **Undefined:**
  - OUT always returns to IDLE.
  - `in_ready=0` in OUT.
  - `in_ready` is purely registered-state decode.

## Test plan
- **Reset values:** assert `rst_n=0` for 2 cycles, then release → `in_ready=1`, `out_valid=0`, `busy=0`, `o1=0`, `o2=0`.
- **`a>2` branch:** `a=3`, `b=7`, `e=9`, `out_ready=1` → `out_valid` 3 cycles after accept; `o1=10`, `o2=12`. Next accept is possible no earlier than 5 cycles after the first.
- **`d` branch and `y=5` default:**
  - `a=2`, `d=4`, `e=6` → `o1=6`, `o2=8` (`c=1` must not be selected).
  - Then `a=1`, `f=11` → `o1=12`, `o2=6`.
- **Width and backpressure:**
  - `a=15`, `b=15`, `e=15`, `out_ready=0` for 6 cycles → `out_valid` held with `o1=30`, `o2=30`, and `in_ready=0` throughout.
  - Raise `out_ready` → one handshake, then IDLE.
- **Reset mid-operation:** pulse `rst_n` low in ADD_O1 → `busy=0` and `out_valid=0` immediately; no result is emitted. The next transaction (`a=0`, `f=2`) yields `o1=2`, `o2=5`.
- **Bypass, with `NESTED_IF_SEQ_CTRL_BYPASS_EN`:** hold `in_valid=1` and `out_ready=1` with a stream of 4 operand sets → results on consecutive 4-cycle intervals, with no IDLE cycle between them. Without the macro, the same stimulus gives 5-cycle intervals.
